// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_ZERO_CHECK_EN to short-circuit divide-by-zero and raise div_by_zero.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH+1:0] shifted;
`ifdef DIV_ZERO_CHECK_EN
  logic             dbz_q, dbz_d;
`endif

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    rem_out_d = rem_out_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d     = dbz_q;
`endif
    // dvd_q doubles as the quotient accumulator: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    shifted = {prem_q, dvd_q[WIDTH-1]};

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          prem_d  = '0;
          cnt_d   = CW'(WIDTH);
          state_d = CALC;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == '0) begin
            state_d   = DONE;
            quot_d    = '1;
            rem_out_d = dividend;
            dbz_d     = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        if (shifted >= {2'b00, dvs_q}) begin
          prem_d = (WIDTH + 1)'(shifted - {2'b00, dvs_q});
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          prem_d = shifted[WIDTH:0];
          dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          quot_d    = dvd_d;
          rem_out_d = prem_d[WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
          dbz_d     = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      quot_q    <= quot_d;
      rem_out_q <= rem_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): vector table plus hand-written
// sequences for ignored start, back-to-back operation and mid-calculation reset.
module tb_seq_divider;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif
  localparam int unsigned NV = 9;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t vecs[NV];

  seq_divider #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: done with empty scoreboard, got q=%0d r=%0d", name, quotient, remainder);
    end else begin
      e = sb.pop_front();
      chk({name, "_q"}, int'(quotient), int'(e.q));
      chk({name, "_r"}, int'(remainder), int'(e.r));
      chk({name, "_dbz"}, int'(div_by_zero), int'(e.dbz));
    end
  endtask

  task automatic push_exp(input logic [7:0] q, input logic [7:0] r, input logic dbz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dbz = dbz;
    sb.push_back(e);
  endtask

  // Called at a falling edge; one-cycle start, then wait (bounded) for done.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input string name);
    int edges;
    int bcnt;
    bit z;
    z = ZCHK && (b == 8'd0);
    push_exp(q, r, z);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    edges    = 0;
    bcnt     = 0;
    do begin
      @(posedge clock);
      @(negedge clock);
      edges++;
      start = 1'b0;
      if (busy) bcnt++;
    end while (!done && edges < 40);
    chk({name, "_lat"}, edges, z ? 1 : 9);
    chk({name, "_busy"}, bcnt, z ? 0 : 8);
    pop_check(name);
    @(posedge clock);
    @(negedge clock);
    chk({name, "_pulse"}, int'(done), 0);
    chk({name, "_hold"}, int'(quotient), int'(q));
  endtask

  initial begin
    int edges;
    int dcount;

    vecs = '{
      '{8'd100, 8'd7,   8'd14,  8'd2},
      '{8'd255, 8'd1,   8'd255, 8'd0},
      '{8'd5,   8'd10,  8'd0,   8'd5},
      '{8'd200, 8'd9,   8'd22,  8'd2},
      '{8'd0,   8'd5,   8'd0,   8'd0},
      '{8'd255, 8'd255, 8'd1,   8'd0},
      '{8'd254, 8'd255, 8'd0,   8'd254},
      '{8'd128, 8'd3,   8'd42,  8'd2},
      '{8'd40,  8'd0,   8'd255, 8'd40}
    };

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clock);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int unsigned i = 0; i < NV; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));

    // start during CALC must be ignored; start held in DONE chains a new op
    push_exp(8'd14, 8'd2, 1'b0);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    edges    = 0;
    do begin
      @(posedge clock);
      @(negedge clock);
      edges++;
      if (edges == 1) start = 1'b0;
      else if (edges == 4) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end else if (edges == 5) start = 1'b0;
    end while (!done && edges < 40);
    chk("ign_lat", edges, 9);
    pop_check("ign");

    push_exp(8'd3, 8'd0, 1'b0);
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_pulse", int'(done), 0);
    edges = 1;
    while (!done && edges < 40) begin
      @(posedge clock);
      @(negedge clock);
      edges++;
    end
    chk("b2b_lat", edges, 9);
    pop_check("b2b");

    // reset in cycle 5 of CALC, with start also high: reset wins, no done
    @(negedge clock);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    for (int unsigned e = 1; e <= 5; e++) begin
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
    end
    chk("mid_busy", int'(busy), 1);
    reset_n  = 1'b0;
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd9;
    @(posedge clock);
    @(negedge clock);
    chk("mrst_q", int'(quotient), 0);
    chk("mrst_r", int'(remainder), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_dbz", int'(div_by_zero), 0);
    reset_n = 1'b1;
    start   = 1'b0;
    dcount  = 0;
    for (int unsigned e = 0; e < 12; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (done || busy) dcount++;
    end
    chk("mrst_quiet", dcount, 0);

    do_op(8'd200, 8'd9, 8'd22, 8'd2, "post_rst");

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
